// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: default counter
// width, channel-index width helper and the un-inverted idle pin level.
package pwm_pkg;

    localparam int DEFAULT_CNT_W = 8;

    // Pin level of a non-inverted channel when it is not driving its pulse;
    // a channel's real idle level is this value XOR its inversion bit.
    localparam logic IDLE_LEVEL = 1'b0;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty written from the register port, active duty
// reloaded at period boundaries (or continuously while stopped) and the
// registered output pin with optional inversion.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             run,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic             inv,
    output logic             pwm_out
);

    logic [CNT_W-1:0] shadow_r;
    logic [CNT_W-1:0] active_r;
    logic             level_s;

    // Un-inverted pin level for the current counter position.
    always_comb begin
        level_s = IDLE_LEVEL;
        if (en && run && (cnt < active_r)) begin
            level_s = ~IDLE_LEVEL;
        end else begin
            level_s = IDLE_LEVEL;
        end
    end

    // Shadow duty captures register-port writes at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= {CNT_W{1'b0}};
        end else if (wr_sel) begin
            shadow_r <= wr_duty;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active duty follows the shadow only at a wrap or while stopped, so a
    // same-cycle write is seen one period later (old shadow value is loaded).
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= {CNT_W{1'b0}};
        end else if (!en || wrap) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Registered output pin with per-channel inversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= IDLE_LEVEL ^ inv;
        end else begin
            pwm_out <= level_s ^ inv;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter, one
// double-buffered duty channel per output, and a one-clock period_end pulse.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                 CHANNELS = 4,
    parameter int                 CNT_W    = DEFAULT_CNT_W,
    parameter int                 PRESCALE = 1,
    parameter logic [CHANNELS-1:0] INV_MASK = {CHANNELS{1'b0}},
    localparam int                CH_W     = ch_idx_w(CHANNELS)
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_cnt_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_act_r;
    logic             run_s;
    logic             tick_s;
    logic             wrap_s;

    // Counting is only meaningful when enabled with a non-zero period.
    always_comb begin
        run_s = 1'b0;
        if (en && (period_act_r != {CNT_W{1'b0}})) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
    end

    // Counter tick at the last prescaler step, and wrap at the last count.
    always_comb begin
        tick_s = 1'b0;
        wrap_s = 1'b0;
        if (run_s && (presc_cnt_r == PRESC_TOP)) begin
            tick_s = 1'b1;
            if (cnt_r == (period_act_r - CNT_W'(1))) begin
                wrap_s = 1'b1;
            end else begin
                wrap_s = 1'b0;
            end
        end else begin
            tick_s = 1'b0;
            wrap_s = 1'b0;
        end
    end

    // Prescaler: counts clocks per tick, held at zero when not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_r <= {PW{1'b0}};
        end else if (!run_s) begin
            presc_cnt_r <= {PW{1'b0}};
        end else if (presc_cnt_r == PRESC_TOP) begin
            presc_cnt_r <= {PW{1'b0}};
        end else begin
            presc_cnt_r <= presc_cnt_r + PW'(1);
        end
    end

    // Period counter wraps modulo period_act, not modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!run_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Active period follows the input only at a wrap or while stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_act_r <= {CNT_W{1'b0}};
        end else if (!en || wrap_s) begin
            period_act_r <= period;
        end else begin
            period_act_r <= period_act_r;
        end
    end

    // One-clock pulse following each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_end <= 1'b0;
        end else begin
            period_end <= wrap_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pwm_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .run     (run_s),
                .wrap    (wrap_s),
                .cnt     (cnt_r),
                .wr_sel  (wr_en && (wr_ch == CH_W'(gi))),
                .wr_duty (wr_duty),
                .inv     (INV_MASK[gi]),
                .pwm_out (pwm_out[gi])
            );
        end
    endgenerate

endmodule
